// File: rtl/bus_ram_responder.sv
// Valid/ready bus target backed by a word-addressed RAM, with a programmable
// pre-accept stall and a fixed read latency for exercising the initiator.
module bus_ram_responder #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH_LOG2   = 8,
  parameter int READ_LATENCY = 2,
  parameter int WAIT_CYCLES  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  err_addr
);

  localparam int  OFF        = $clog2(DATA_WIDTH / 8);
  localparam int  DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic READY_IDLE = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_STALL, S_ACCEPT, S_RDWAIT} state_t;

  state_t                 state_q;
  logic [3:0]             wait_q;
  logic [1:0]             lat_q;
  logic                   req_ready_q;
  logic                   rsp_valid_q;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q;
  logic                   err_addr_q;
  logic                   rd_oor_q;
  logic [DATA_WIDTH-1:0]  rd_data_q;
  logic [DATA_WIDTH-1:0]  mem [0:DEPTH-1];

  logic                   accept;
  logic                   addr_oor;
  logic [DEPTH_LOG2-1:0]  idx;

  assign accept   = req_valid & req_ready_q;
  assign idx      = req_addr[OFF +: DEPTH_LOG2];
  assign addr_oor = |(req_addr >> (OFF + DEPTH_LOG2));

  // RAM array without reset so it maps onto block RAM; read port is registered.
  always_ff @(posedge clk) begin
    if (accept && req_write && !addr_oor) begin
      mem[idx] <= req_wdata;
    end
    if (accept && !req_write) begin
      rd_data_q <= mem[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      lat_q       <= '0;
      req_ready_q <= READY_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      err_addr_q  <= 1'b0;
      rd_oor_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      err_addr_q  <= accept & addr_oor;
      if (accept && !req_write) begin
        rd_oor_q <= addr_oor;
      end

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (!req_write) begin
              state_q     <= S_RDWAIT;
              req_ready_q <= 1'b0;
              lat_q       <= 2'(READ_LATENCY - 1);
              // A single-cycle latency has no spare cycle for the registered read.
              if (READ_LATENCY == 1) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= addr_oor ? '0 : mem[idx];
              end
            end
          end else if (req_valid && (WAIT_CYCLES > 0)) begin
            wait_q <= 4'(WAIT_CYCLES - 1);
            if (WAIT_CYCLES == 1) begin
              state_q     <= S_ACCEPT;
              req_ready_q <= 1'b1;
            end else begin
              state_q <= S_STALL;
            end
          end
        end

        S_STALL: begin
          if (!req_valid) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
          end else if (wait_q <= 4'd1) begin
            // Ready is registered, so leave one count early to land on T0+W.
            state_q     <= S_ACCEPT;
            req_ready_q <= 1'b1;
            wait_q      <= '0;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end

        S_ACCEPT: begin
          req_ready_q <= 1'b0;
          if (accept && !req_write) begin
            state_q <= S_RDWAIT;
            lat_q   <= 2'(READ_LATENCY - 1);
            if (READ_LATENCY == 1) begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= addr_oor ? '0 : mem[idx];
            end
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_RDWAIT: begin
          if (lat_q == 2'd0) begin
            state_q     <= S_IDLE;
            req_ready_q <= READY_IDLE;
          end else begin
            lat_q <= lat_q - 2'd1;
            if (lat_q == 2'd1) begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rd_oor_q ? '0 : rd_data_q;
            end
          end
        end

        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= READY_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Directed bench: instance 0 runs with no stall, instance 1 with a 3-cycle stall,
// both with a 2-cycle read latency.
module tb_bus_ram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [2];
  logic        req_write [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_rdata [2];
  logic        err_addr  [2];

  int tests  = 0;
  int failed = 0;

  bus_ram_responder #(.READ_LATENCY(2), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_write(req_write[0]),
    .req_wdata(req_wdata[0]), .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .err_addr(err_addr[0])
  );

  bus_ram_responder #(.READ_LATENCY(2), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_write(req_write[1]),
    .req_wdata(req_wdata[1]), .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .err_addr(err_addr[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Holds the request until accepted; returns at the cycle after the accept edge.
  task automatic do_req(input int d, input logic [15:0] addr, input logic wr,
                        input logic [15:0] wd, output int waited);
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    req_write[d] = wr;
    req_wdata[d] = wd;
    waited = 0;
    while (req_ready[d] !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk("accept_timeout", {31'd0, req_ready[d]}, 32'd1);
    tick();
    req_valid[d] = 1'b0;
    $display("[TB] dut%0d %s addr=0x%04h wdata=0x%04h waited=%0d",
             d, wr ? "write" : "read ", addr, wd, waited);
  endtask

  task automatic wr_req(input int d, input logic [15:0] addr, input logic [15:0] wd,
                        input logic exp_err);
    int w;
    do_req(d, addr, 1'b1, wd, w);
    chk("wr_wait", w, (d == 0) ? 0 : 3);
    chk("wr_err", {31'd0, err_addr[d]}, {31'd0, exp_err});
    chk("wr_ready_after", {31'd0, req_ready[d]}, (d == 0) ? 1 : 0);
    chk("wr_no_rsp", {31'd0, rsp_valid[d]}, 0);
    tick();
    chk("wr_err_clear", {31'd0, err_addr[d]}, 0);
  endtask

  task automatic rd_req(input int d, input logic [15:0] addr, input logic [15:0] exp,
                        input logic exp_err);
    int w;
    do_req(d, addr, 1'b0, 16'h0000, w);
    chk("rd_wait", w, (d == 0) ? 0 : 3);
    chk("rd_t1_err", {31'd0, err_addr[d]}, {31'd0, exp_err});
    chk("rd_t1_valid", {31'd0, rsp_valid[d]}, 0);
    chk("rd_t1_ready", {31'd0, req_ready[d]}, 0);
    tick();
    chk("rd_t2_valid", {31'd0, rsp_valid[d]}, 1);
    chk("rd_t2_data", {16'd0, rsp_rdata[d]}, {16'd0, exp});
    chk("rd_t2_ready", {31'd0, req_ready[d]}, 0);
    chk("rd_t2_err", {31'd0, err_addr[d]}, 0);
    tick();
    chk("rd_t3_valid", {31'd0, rsp_valid[d]}, 0);
    chk("rd_t3_hold", {16'd0, rsp_rdata[d]}, {16'd0, exp});
    chk("rd_t3_ready", {31'd0, req_ready[d]}, (d == 0) ? 1 : 0);
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
    end
    tick(); tick(); tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'd0, req_ready[d]}, (d == 0) ? 1 : 0);
      chk("rst_rsp_valid", {31'd0, rsp_valid[d]}, 0);
      chk("rst_rdata", {16'd0, rsp_rdata[d]}, 0);
      chk("rst_err", {31'd0, err_addr[d]}, 0);
    end
    rst_n = 1'b1;
    tick();

    // No stall: write then read back, read response two cycles after accept
    wr_req(0, 16'h0010, 16'h1234, 1'b0);
    rd_req(0, 16'h0010, 16'h1234, 1'b0);

    // Byte offset bits are ignored
    wr_req(0, 16'h0021, 16'hBEEF, 1'b0);
    rd_req(0, 16'h0020, 16'hBEEF, 1'b0);

    // Out of range: 0x0200 is word 0x100, which aliases word 0 if unchecked
    wr_req(0, 16'h0000, 16'h5A5A, 1'b0);
    rd_req(0, 16'h0200, 16'h0000, 1'b1);
    wr_req(0, 16'h0200, 16'hFFFF, 1'b1);
    rd_req(0, 16'h0000, 16'h5A5A, 1'b0);

    // Four back-to-back writes with valid held high
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr[0]  = 16'h0040 + 16'(2 * i);
      req_wdata[0] = 16'h1111 * 16'(i + 1);
      chk("burst_ready", {31'd0, req_ready[0]}, 1);
      tick();
      $display("[TB] dut0 write addr=0x%04h wdata=0x%04h burst beat %0d",
               req_addr[0], req_wdata[0], i);
      chk("burst_err", {31'd0, err_addr[0]}, 0);
    end
    req_valid[0] = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      rd_req(0, 16'h0040 + 16'(2 * i), 16'h1111 * 16'(i + 1), 1'b0);
    end

    // Reset one cycle after a read accept drops the pending response
    do_req(0, 16'h0010, 1'b0, 16'h0000, w);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, rsp_valid[0]}, 0);
    chk("midrst_ready", {31'd0, req_ready[0]}, 1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("postrst_no_rsp", {31'd0, rsp_valid[0]}, 0);
      chk("postrst_ready", {31'd0, req_ready[0]}, 1);
    end
    $display("[TB] dut0 reset during read, response dropped");

    // Three-cycle stall: ready exactly three cycles after valid rises
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 16'h0002;
    req_wdata[1] = 16'hCAFE;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready_low", {31'd0, req_ready[1]}, 0);
      tick();
    end
    chk("stall_ready_high", {31'd0, req_ready[1]}, 1);
    tick();
    req_valid[1] = 1'b0;
    $display("[TB] dut1 write addr=0x0002 wdata=0xCAFE after 3 stall cycles");
    chk("stall_after_accept", {31'd0, req_ready[1]}, 0);
    tick();
    chk("stall_gap", {31'd0, req_ready[1]}, 0);
    rd_req(1, 16'h0002, 16'hCAFE, 1'b0);

    // Valid dropped during the stall: nothing is accepted
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 16'h0002;
    req_wdata[1] = 16'h0000;
    tick();
    tick();
    req_valid[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_ready", {31'd0, req_ready[1]}, 0);
      tick();
    end
    $display("[TB] dut1 write addr=0x0002 abandoned during stall");
    rd_req(1, 16'h0002, 16'hCAFE, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
